// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: decodes gate beam-break sequences into car entry/exit events and a saturating occupancy count
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   a, b   - outer / inner beam sensors, 1 = beam blocked
//   count  - current occupancy, 0..CAPACITY, feeds the seven-segment decoder
//   enter  - one-cycle pulse on a completed entry sequence (10,11,01,00)
//   exit_p - one-cycle pulse on a completed exit sequence (01,11,10,00)
//   full   - count == CAPACITY
//   empty  - count == 0
// Build option: define PARKING_INPUT_SYNC_EN to pass a and b through two-flop
// synchronizers before the FSM (two extra cycles of latency); leave it undefined
// when the inputs are already synchronous to clk.
module parking_occupancy_counter #(
   parameter int CAPACITY = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic [4:0] count,
   output logic       enter,
   output logic       exit_p,
   output logic       full,
   output logic       empty
);
   typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ABORT} state_t;
   state_t     state_q, state_d;
   logic [4:0] count_q;
   logic       enter_q, exit_q;
   logic       ev_in, ev_out;
   logic [1:0] s;
`ifdef PARKING_INPUT_SYNC_EN
   logic [1:0] sync1_q, sync2_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {a, b};
         sync2_q <= sync1_q;
      end
   end
   assign s = sync2_q;
`else
   assign s = {a, b};
`endif
   // Each path state holds on its own pattern, steps forward, backs up one step,
   // and drops to IDLE on 00; anything else is a skipped step and aborts.
   always_comb begin
      state_d = ABORT;
      ev_in   = 1'b0;
      ev_out  = 1'b0;
      case (state_q)
         IDLE:  state_d = s == 2'b00 ? IDLE : s == 2'b10 ? IN1 : s == 2'b01 ? OUT1 : ABORT;
         IN1:   state_d = s == 2'b10 ? IN1  : s == 2'b11 ? IN2 : s == 2'b00 ? IDLE : ABORT;
         IN2:   state_d = s == 2'b11 ? IN2  : s == 2'b01 ? IN3 : s == 2'b10 ? IN1  : IDLE;
         IN3: begin
            state_d = s == 2'b01 ? IN3 : s == 2'b11 ? IN2 : s == 2'b00 ? IDLE : ABORT;
            ev_in   = s == 2'b00;
         end
         OUT1:  state_d = s == 2'b01 ? OUT1 : s == 2'b11 ? OUT2 : s == 2'b00 ? IDLE : ABORT;
         OUT2:  state_d = s == 2'b11 ? OUT2 : s == 2'b10 ? OUT3 : s == 2'b01 ? OUT1 : IDLE;
         OUT3: begin
            state_d = s == 2'b10 ? OUT3 : s == 2'b11 ? OUT2 : s == 2'b00 ? IDLE : ABORT;
            ev_out  = s == 2'b00;
         end
         ABORT: state_d = s == 2'b00 ? IDLE : ABORT;
      endcase
   end
   // Events always pulse; the count saturates at both ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= 5'd0;
         enter_q <= 1'b0;
         exit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         enter_q <= ev_in;
         exit_q  <= ev_out;
         if (ev_in && count_q != 5'(CAPACITY))
            count_q <= count_q + 5'd1;
         else if (ev_out && count_q != 5'd0)
            count_q <= count_q - 5'd1;
      end
   end
   assign count  = count_q;
   assign enter  = enter_q;
   assign exit_p = exit_q;
   assign full   = count_q == 5'(CAPACITY);
   assign empty  = count_q == 5'd0;
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb_parking_occupancy_counter: directed bench for the gate sequence decoder and occupancy counter
module tb_parking_occupancy_counter;
`ifdef PARKING_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   logic       clk = 1'b0, reset = 1'b1, a = 1'b0, b = 1'b0;
   logic [4:0] count;
   logic       enter, exit_p, full, empty;
   int         vec = 0, bad = 0, n_en = 0, n_ex = 0, n_both = 0;
   int         e0, x0;

   parking_occupancy_counter #(.CAPACITY(25)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b),
      .count(count), .enter(enter), .exit_p(exit_p), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (enter) n_en++;
      if (exit_p) n_ex++;
      if (enter && exit_p) n_both++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] ab, input int n);
      @(negedge clk);
      {a, b} = ab;
      repeat (n) @(posedge clk);
   endtask

   task automatic car_in();
      step(2'b10, 2); step(2'b11, 2); step(2'b01, 2); step(2'b00, LAT + 2);
      #2;
   endtask

   task automatic car_out();
      step(2'b01, 2); step(2'b11, 2); step(2'b10, 2); step(2'b00, LAT + 2);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_pulses", {enter, exit_p}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("idle_count", count, 0);
      chk("idle_pulses", n_en + n_ex, 0);

      e0 = n_en; car_in();
      chk("entry1_pulse", n_en - e0, 1);
      chk("entry1_count", count, 1);
      chk("entry1_empty", empty, 0);
      chk("entry1_full", full, 0);

      for (int i = 0; i < 24; i++) car_in();
      chk("cap_count", count, 25);
      chk("cap_full", full, 1);
      e0 = n_en; car_in();
      chk("sat_pulse", n_en - e0, 1);
      chk("sat_count", count, 25);
      chk("sat_full", full, 1);

      for (int i = 0; i < 25; i++) car_out();
      chk("drain_count", count, 0);
      chk("drain_empty", empty, 1);
      x0 = n_ex; car_out();
      chk("exit0_pulse", n_ex - x0, 1);
      chk("exit0_count", count, 0);

      for (int i = 0; i < 3; i++) car_in();
      chk("three_count", count, 3);
      x0 = n_ex; car_out();
      chk("exit3_pulse", n_ex - x0, 1);
      chk("exit3_count", count, 2);

      e0 = n_en; x0 = n_ex;
      step(2'b10, 2); step(2'b11, 2); step(2'b10, 2); step(2'b00, LAT + 2); #2;
      chk("backup_pulse", (n_en - e0) + (n_ex - x0), 0);
      chk("backup_count", count, 2);
      step(2'b10, 2); step(2'b01, 2); step(2'b00, LAT + 2); #2;
      chk("skip_pulse", (n_en - e0) + (n_ex - x0), 0);
      chk("skip_count", count, 2);
      step(2'b11, 2); step(2'b00, LAT + 2); #2;
      chk("idle11_pulse", (n_en - e0) + (n_ex - x0), 0);
      chk("idle11_count", count, 2);
      step(2'b10, 2); step(2'b01, 2); step(2'b00, LAT + 2); step(2'b01, 2);
      step(2'b11, 2); step(2'b10, 2); step(2'b00, LAT + 2); #2;
      chk("abort_then_exit", n_ex - x0, 1);
      chk("abort_then_exit_count", count, 1);

      e0 = n_en;
      step(2'b10, 2); step(2'b11, 2); step(2'b01, 2); step(2'b11, 2);
      step(2'b01, 2); step(2'b00, LAT + 2); #2;
      chk("retry_pulse", n_en - e0, 1);
      chk("retry_count", count, 2);

      for (int i = 0; i < 5; i++) car_in();
      chk("seven_count", count, 7);
      e0 = n_en; x0 = n_ex;
      step(2'b10, 2); step(2'b11, 2); step(2'b01, LAT + 2);
      @(negedge clk);
      reset = 1'b1;
      {a, b} = 2'b00;
      @(posedge clk);
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_empty", empty, 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #2;
      chk("midrst_pulse", (n_en - e0) + (n_ex - x0), 0);
      chk("midrst_count_after", count, 0);

      step(2'b10, 2); step(2'b11, 2); step(2'b01, LAT + 2);
      @(negedge clk);
      {a, b} = 2'b00;
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("lat_before_count", count, 0);
      chk("lat_before_enter", enter, 0);
      @(posedge clk);
      #1;
      chk("lat_edge_count", count, 1);
      chk("lat_edge_enter", enter, 1);
      @(posedge clk);
      #1;
      chk("lat_one_cycle", enter, 0);

      car_in();
      chk("b2b_count", count, 2);
      chk("never_both", n_both, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
